program_loader: RTL

//  Transmitter side of the CPU instruction-load port (LoadInstructions/Instruction).

---
 rtl/program_loader_if.sv | 21 ++
 rtl/program_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream source and CPU instruction-load port of the program loader.
// The master side is the byte source / observer; the slave side is the loader.
interface program_loader_if;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        LoadDone;
  logic        CPUReset;
  logic        LoadInstructions;
  logic [31:0] Instruction;

  modport master (
    output ByteIn, ByteValid, LoadDone,
    input  ByteReady, CPUReset, LoadInstructions, Instruction
  );

  modport slave (
    input  ByteIn, ByteValid, LoadDone,
    output ByteReady, CPUReset, LoadInstructions, Instruction
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: collects a big-endian byte stream into 32-bit words, then
// holds the CPU in reset, bursts the words into instruction memory on
// consecutive cycles, resets the CPU again and releases it to run.
module program_loader #(
  parameter int DEPTH      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       Start,
  program_loader_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] WordCount,
  output logic                       Busy,
  output logic                       Loaded
);
  localparam int WC_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [WC_W-1:0] FULL     = WC_W'(DEPTH);
  localparam logic [CW-1:0]   RST_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, PRERST, BURST, POSTRST, RUN} state_t;
  state_t state, next_state;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     partial, partial_next, merged, wr_data;
  logic [1:0]      byte_idx, byte_idx_next;
  logic [WC_W-1:0] word_count_next;
  logic [AW-1:0]   rd_ptr, rd_addr, wr_addr;
  logic [CW-1:0]   rst_cnt;
  logic            byte_ready, xfer, wr_en, pending, burst_last;
  logic [31:0]     instr_p1;
  logic            vld_p1, cpu_rst_p1;

  assign byte_ready = (state == COLLECT) && (WordCount != FULL);
  assign xfer       = bus.ByteValid && byte_ready;
  assign burst_last = (WC_W'(rd_ptr) == WordCount - WC_W'(1));
  // Next burst word: first word when entering BURST, otherwise the one after rd_ptr.
  assign rd_addr    = (state == BURST) ? rd_ptr + AW'(1) : '0;
  assign wr_addr    = WordCount[AW-1:0];

  assign bus.ByteReady        = byte_ready;
  assign bus.CPUReset         = cpu_rst_p1;
  assign bus.LoadInstructions = vld_p1;
  assign bus.Instruction      = instr_p1;
  assign Busy   = (state == COLLECT) || (state == PRERST) ||
                  (state == BURST)   || (state == POSTRST);
  assign Loaded = (state == RUN);

  // Place the incoming byte into the lane selected by the byte index (MSB first).
  always_comb begin
    merged = partial;
    case (byte_idx)
      2'd0:    merged = {bus.ByteIn, 24'h0};
      2'd1:    merged = {partial[31:24], bus.ByteIn, 16'h0};
      2'd2:    merged = {partial[31:16], bus.ByteIn, 8'h0};
      default: merged = {partial[31:8], bus.ByteIn};
    endcase
  end

  // Next-state, packing and buffer-write decisions.
  always_comb begin
    next_state      = state;
    word_count_next = WordCount;
    byte_idx_next   = byte_idx;
    partial_next    = partial;
    wr_en           = 1'b0;
    wr_data         = merged;
    pending         = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (Start) begin
          next_state      = COLLECT;
          word_count_next = '0;
          byte_idx_next   = '0;
          partial_next    = '0;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (byte_idx == 2'd3) begin
            wr_en           = 1'b1;
            word_count_next = WordCount + WC_W'(1);
            byte_idx_next   = '0;
            partial_next    = '0;
          end else begin
            byte_idx_next = byte_idx + 2'd1;
            partial_next  = merged;
          end
        end
        if (WordCount == FULL) begin
          next_state = PRERST;
        end else if (bus.LoadDone) begin
          // A byte accepted this cycle is folded in before flushing the partial word.
          pending = xfer ? (byte_idx != 2'd3) : (byte_idx != 2'd0);
          if (pending) begin
            wr_en           = 1'b1;
            wr_data         = xfer ? merged : partial;
            word_count_next = WordCount + WC_W'(1);
            byte_idx_next   = '0;
            partial_next    = '0;
          end
          next_state = (word_count_next == '0) ? IDLE : PRERST;
        end
      end
      PRERST:  if (rst_cnt == RST_LAST) next_state = BURST;
      BURST:   if (burst_last) next_state = POSTRST;
      POSTRST: if (rst_cnt == RST_LAST) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // Control state: FSM, counters and pointers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      WordCount <= '0;
      byte_idx  <= '0;
      rd_ptr    <= '0;
      rst_cnt   <= '0;
    end else begin
      state     <= next_state;
      WordCount <= word_count_next;
      byte_idx  <= byte_idx_next;
      rd_ptr    <= (state == BURST) ? rd_ptr + AW'(1) : '0;
      rst_cnt   <= (next_state == state) ? rst_cnt + CW'(1) : '0;
    end
  end

  // Packing register and word buffer hold data only; no reset needed.
  always_ff @(posedge clk) begin
    partial <= partial_next;
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // ---- stage p1: CPU port outputs registered from the next state ----
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cpu_rst_p1 <= 1'b1;
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
    end else begin
      cpu_rst_p1 <= !((next_state == BURST) || (next_state == RUN));
      vld_p1     <= (next_state == BURST);
      instr_p1   <= (next_state == BURST) ? mem[rd_addr] : '0;
    end
  end
endmodule
